// File: rtl/addsub_pkg.sv
// Shared encodings for the add/sub accumulator: controller states and operation select.
package addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_ACC  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder/subtractor; subtraction is a + ~b + 1.
module addsub_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] carry;

    assign carry[0] = sub;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            logic bx;
            assign bx         = b[i] ^ sub;
            assign sum[i]     = a[i] ^ bx ^ carry[i];
            assign carry[i+1] = (a[i] & bx) | (carry[i] & (a[i] ^ bx));
        end
    endgenerate

    assign cout = carry[WIDTH];
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/addsub_accumulator.sv
// Burst accumulator: sums len operands (add or subtract each) and hands the total
// plus sticky carry/borrow and overflow flags downstream over valid/ready.
//
//  state  | meaning
//  S_IDLE | waiting for start; previous result still visible on acc_out/flags
//  S_ACC  | accepting operands, one per cycle, until cnt reaches zero
//  S_DONE | result valid, held until out_ready
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   acc_out,
    output logic               carry_flg,
    output logic               ovf_flg,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   core_sum;
    logic               core_cout;
    logic               core_ovf;
    logic               xfer;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a    (acc_q),
        .b    (in_data),
        .sub  (in_sub == OP_SUB),
        .sum  (core_sum),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    assign xfer = in_valid && (state_q == S_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (xfer) begin
                    acc_d   = core_sum;
                    cnt_d   = cnt_q - 1'b1;
                    // A subtract with no carry out means it borrowed.
                    carry_d = carry_q | ((in_sub == OP_ADD) ? core_cout : ~core_cout);
                    ovf_d   = ovf_q | core_ovf;
                    if (cnt_q == COUNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_ACC) || (state_q == S_DONE);
        acc_out   = acc_q;
        carry_flg = carry_q;
        ovf_flg   = ovf_q;
    end

endmodule
